// File: rtl/intersection_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : intersection_scheduler
// Brief    : Two-road intersection sequencer (A main, B side, pedestrian phase)
//            with round-robin service; optional NIGHT_MODE_EN flashing mode.
// Revision : 1.0
// =============================================================================
module intersection_scheduler #(
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 20,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2,
    parameter int T_GREEN_B   = 15,
    parameter int T_PED       = 10,
    parameter int T_FLASH     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_b,
    input  logic       ped_btn,
    input  logic       night,
    output logic [2:0] car_a,
    output logic [2:0] car_b,
    output logic       ped_walk,
    output logic       ped_wait,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_A_GRN   = 3'd0,
        S_A_YEL   = 3'd1,
        S_ALL_RED = 3'd2,
        S_B_GRN   = 3'd3,
        S_B_YEL   = 3'd4,
        S_PED     = 3'd5,
        S_FLASH   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] c_grn_last  = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] c_yel_last  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] c_ar_last   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] c_grnb_last = CNT_W'(T_GREEN_B - 1);
    localparam logic [CNT_W-1:0] c_ped_last  = CNT_W'(T_PED - 1);
    localparam logic [2:0]       c_red = 3'b100;
    localparam logic [2:0]       c_yel = 3'b010;
    localparam logic [2:0]       c_grn = 3'b001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_b_q, pend_b_d;
    logic             pend_ped_q, pend_ped_d;
    logic             tgt_ped_q, tgt_ped_d;    // 1: pedestrian phase is the pending target
    logic             last_ped_q, last_ped_d;  // 1: pedestrian phase was served last
    logic             from_a_q, from_a_d;      // ALL_RED was entered from A_YEL

`ifdef NIGHT_MODE_EN
    localparam logic [CNT_W-1:0] c_flash_last = CNT_W'(T_FLASH - 1);
    logic flash_off_q, flash_off_d;
`else
    logic w_unused_night;
    assign w_unused_night = night;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A_GRN;
            cnt_q      <= '0;
            pend_b_q   <= 1'b0;
            pend_ped_q <= 1'b0;
            tgt_ped_q  <= 1'b0;
            last_ped_q <= 1'b1;
            from_a_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_b_q   <= pend_b_d;
            pend_ped_q <= pend_ped_d;
            tgt_ped_q  <= tgt_ped_d;
            last_ped_q <= last_ped_d;
            from_a_q   <= from_a_d;
        end
    end

`ifdef NIGHT_MODE_EN
    always_ff @(posedge clk) begin
        if (rst) flash_off_q <= 1'b0;
        else     flash_off_q <= flash_off_d;
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        pend_b_d   = pend_b_q | (sensor_b & (state_q != S_B_GRN));
        pend_ped_d = pend_ped_q | (ped_btn & (state_q != S_PED));
        tgt_ped_d  = tgt_ped_q;
        last_ped_d = last_ped_q;
        from_a_d   = from_a_q;
`ifdef NIGHT_MODE_EN
        flash_off_d = flash_off_q;
`endif
        case (state_q)
            S_A_GRN: begin
                if (cnt_q == c_grn_last) begin
                    cnt_d = cnt_q;
`ifdef NIGHT_MODE_EN
                    if (night) begin
                        state_d     = S_FLASH;
                        cnt_d       = '0;
                        pend_b_d    = 1'b0;
                        pend_ped_d  = 1'b0;
                        flash_off_d = 1'b0;
                    end else
`endif
                    if (pend_b_q || pend_ped_q) begin
                        state_d   = S_A_YEL;
                        cnt_d     = '0;
                        // Both pending: serve whichever did not go last.
                        tgt_ped_d = (pend_b_q && pend_ped_q) ? ~last_ped_q : pend_ped_q;
                    end
                end
            end
            S_A_YEL: begin
                if (cnt_q == c_yel_last) begin
                    state_d  = S_ALL_RED;
                    cnt_d    = '0;
                    from_a_d = 1'b1;
                end
            end
            S_ALL_RED: begin
                if (cnt_q == c_ar_last) begin
                    cnt_d    = '0;
                    from_a_d = 1'b0;
                    if (from_a_q) begin
                        last_ped_d = tgt_ped_q;
                        if (tgt_ped_q) begin
                            state_d    = S_PED;
                            pend_ped_d = 1'b0;
                        end else begin
                            state_d  = S_B_GRN;
                            pend_b_d = 1'b0;
                        end
                    end else begin
                        state_d = S_A_GRN;
                    end
                end
            end
            S_B_GRN: begin
                if (cnt_q == c_grnb_last) begin
                    state_d = S_B_YEL;
                    cnt_d   = '0;
                end
            end
            S_B_YEL: begin
                if (cnt_q == c_yel_last) begin
                    state_d  = S_ALL_RED;
                    cnt_d    = '0;
                    from_a_d = 1'b0;
                end
            end
            S_PED: begin
                if (cnt_q == c_ped_last) begin
                    state_d  = S_ALL_RED;
                    cnt_d    = '0;
                    from_a_d = 1'b0;
                end
            end
`ifdef NIGHT_MODE_EN
            S_FLASH: begin
                pend_b_d   = pend_b_q;
                pend_ped_d = pend_ped_q;
                if (!night) begin
                    state_d  = S_ALL_RED;
                    cnt_d    = '0;
                    from_a_d = 1'b0;
                end else if (cnt_q == c_flash_last) begin
                    cnt_d       = '0;
                    flash_off_d = ~flash_off_q;
                end
            end
`endif
            default: begin
                state_d  = S_ALL_RED;
                cnt_d    = '0;
                from_a_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        car_a    = c_red;
        car_b    = c_red;
        ped_walk = 1'b0;
        case (state_q)
            S_A_GRN: car_a    = c_grn;
            S_A_YEL: car_a    = c_yel;
            S_B_GRN: car_b    = c_grn;
            S_B_YEL: car_b    = c_yel;
            S_PED:   ped_walk = 1'b1;
`ifdef NIGHT_MODE_EN
            S_FLASH: begin
                car_a = flash_off_q ? 3'b000 : c_yel;
                car_b = flash_off_q ? 3'b000 : c_yel;
            end
`endif
            default: ;
        endcase
    end

    assign ped_wait = pend_ped_q;
    assign phase    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// =============================================================================
// Module   : tb_intersection_scheduler
// Brief    : Directed bench for intersection_scheduler with a schedule-queue
//            reference model and literal checkpoints.
// Revision : 1.0
// =============================================================================
module tb_intersection_scheduler;

    localparam int T_GREEN_MIN = 20;
    localparam int T_YELLOW    = 4;
    localparam int T_ALLRED    = 2;
    localparam int T_GREEN_B   = 15;
    localparam int T_PED       = 10;
    localparam int T_FLASH     = 8;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor_b = 1'b0;
    logic       ped_btn = 1'b0;
    logic       night = 1'b0;
    logic [2:0] car_a, car_b, phase;
    logic       ped_walk, ped_wait;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit model_on = 1'b0;

    intersection_scheduler #(
        .CNT_W(8), .T_GREEN_MIN(T_GREEN_MIN), .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED),
        .T_GREEN_B(T_GREEN_B), .T_PED(T_PED), .T_FLASH(T_FLASH)
    ) dut (
        .clk(clk), .rst(rst), .sensor_b(sensor_b), .ped_btn(ped_btn), .night(night),
        .car_a(car_a), .car_b(car_b), .ped_walk(ped_walk), .ped_wait(ped_wait),
        .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: A green is the resting condition; a service decision
    // pushes the whole per-cycle lamp schedule of the excursion into a queue.
    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       w;
        logic       clr_b;
        logic       clr_p;
    } seg_t;

    seg_t sched[$];
    int   age;
    bit   pb, pp, last_ped;

    task automatic push(input logic [2:0] a, input logic [2:0] b, input logic w,
                        input int n, input bit clr_b, input bit clr_p);
        for (int i = 0; i < n; i++)
            sched.push_back('{a: a, b: b, w: w, clr_b: (i == 0) && clr_b, clr_p: (i == 0) && clr_p});
    endtask

    always @(posedge clk) begin
        bit cur_bg, cur_w, pb_n, pp_n, srv_ped;
        if (rst) begin
            sched.delete();
            age = 0; pb = 0; pp = 0; last_ped = 1; cyc = 0;
        end else begin
            cur_bg = (sched.size() > 0) && (sched[0].b == GRN);
            cur_w  = (sched.size() > 0) && sched[0].w;
            pb_n = pb | (sensor_b & ~cur_bg);
            pp_n = pp | (ped_btn & ~cur_w);
            if (sched.size() > 0) begin
                void'(sched.pop_front());
                if (sched.size() > 0) begin
                    if (sched[0].clr_b) pb_n = 0;
                    if (sched[0].clr_p) pp_n = 0;
                end else begin
                    age = 0;
                end
            end else if (age >= T_GREEN_MIN - 1 && (pb || pp)) begin
                srv_ped  = (pb && pp) ? !last_ped : pp;
                last_ped = srv_ped;
                push(YEL, RED, 0, T_YELLOW, 0, 0);
                push(RED, RED, 0, T_ALLRED, 0, 0);
                if (srv_ped) begin
                    push(RED, RED, 1, T_PED, 0, 1);
                end else begin
                    push(RED, GRN, 0, T_GREEN_B, 1, 0);
                    push(RED, YEL, 0, T_YELLOW, 0, 0);
                end
                push(RED, RED, 0, T_ALLRED, 0, 0);
            end else begin
                age++;
            end
            pb = pb_n; pp = pp_n;
            cyc++;
        end
    end

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (cycle %0d, t=%0t)", nm, got, exp, cyc, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("model_car_a", 4'(car_a), 4'(sched.size() > 0 ? sched[0].a : GRN));
            chk("model_car_b", 4'(car_b), 4'(sched.size() > 0 ? sched[0].b : RED));
            chk("model_walk", 4'(ped_walk), 4'(sched.size() > 0 ? sched[0].w : 1'b0));
            chk("model_wait", 4'(ped_wait), 4'(pp));
        end
    end

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input bit use_model);
        model_on = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sensor_b = 1'b0;
        ped_btn = 1'b0;
        model_on = use_model;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        // Idle; night is driven high in the default build to show it is ignored.
        do_reset(1);
`ifndef NIGHT_MODE_EN
        night = 1'b1;
`endif
        chk("reset_car_a", 4'(car_a), 4'b0001);
        chk("reset_car_b", 4'(car_b), 4'b0100);
        chk("reset_walk", 4'(ped_walk), 4'b0000);
        chk("reset_wait", 4'(ped_wait), 4'b0000);
        goto(199);
        chk("idle_car_a", 4'(car_a), 4'b0001);
        chk("idle_car_b", 4'(car_b), 4'b0100);
        night = 1'b0;

        // Pedestrian request
        do_reset(1);
        goto(5);  ped_btn = 1'b1;
        goto(6);  ped_btn = 1'b0;
        chk("ped_wait_set", 4'(ped_wait), 4'b0001);
        goto(19); chk("ped_a_grn_last", 4'(car_a), 4'b0001);
        goto(20); chk("ped_a_yel", 4'(car_a), 4'b0010);
        goto(24); chk("ped_allred_a", 4'(car_a), 4'b0100);
                  chk("ped_allred_b", 4'(car_b), 4'b0100);
        goto(26); chk("ped_walk_on", 4'(ped_walk), 4'b0001);
                  chk("ped_wait_clr", 4'(ped_wait), 4'b0000);
        goto(35); chk("ped_walk_last", 4'(ped_walk), 4'b0001);
        goto(36); chk("ped_walk_off", 4'(ped_walk), 4'b0000);
        goto(38); chk("ped_back_a_grn", 4'(car_a), 4'b0001);
        goto(45);

        // Simultaneous requests; sensor_b during B green must be ignored
        do_reset(1);
        goto(3);  sensor_b = 1'b1; ped_btn = 1'b1;
        goto(4);  sensor_b = 1'b0; ped_btn = 1'b0;
        goto(25); chk("sim_allred_b", 4'(car_b), 4'b0100);
        goto(26); chk("sim_b_grn", 4'(car_b), 4'b0001);
        goto(30); sensor_b = 1'b1;
        goto(31); sensor_b = 1'b0;
        goto(40); chk("sim_b_grn_last", 4'(car_b), 4'b0001);
        goto(41); chk("sim_b_yel", 4'(car_b), 4'b0010);
        goto(45); chk("sim_allred_a", 4'(car_a), 4'b0100);
        goto(47); chk("sim_a_grn", 4'(car_a), 4'b0001);
                  chk("sim_ped_still", 4'(ped_wait), 4'b0001);
        goto(66); chk("sim_a_grn_last", 4'(car_a), 4'b0001);
        goto(67); chk("sim_a_yel", 4'(car_a), 4'b0010);
        goto(73); chk("sim_ped_walk", 4'(ped_walk), 4'b0001);
        goto(110); chk("sim_idle_after", 4'(car_a), 4'b0001);

        // Late request with a long sensor level spanning the B phase
        do_reset(1);
        goto(100); sensor_b = 1'b1;
        goto(101); sensor_b = 1'b0;
                   chk("late_a_grn", 4'(car_a), 4'b0001);
        goto(102); chk("late_a_yel", 4'(car_a), 4'b0010);
        goto(107); chk("late_allred", 4'(car_b), 4'b0100);
        goto(108); chk("late_b_grn", 4'(car_b), 4'b0001);
        goto(120); sensor_b = 1'b1;
        goto(126); sensor_b = 1'b0;
        goto(190);

        // Reset mid-walk; a press during the walk is ignored
        do_reset(1);
        goto(5);  ped_btn = 1'b1;
        goto(6);  ped_btn = 1'b0;
        goto(28); ped_btn = 1'b1;
        goto(29); ped_btn = 1'b0;
                  chk("walk_press_ignored", 4'(ped_wait), 4'b0000);
        goto(30); chk("walk_before_rst", 4'(ped_walk), 4'b0001);
        ped_btn = 1'b1; sensor_b = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; ped_btn = 1'b0; sensor_b = 1'b0;
        chk("rst_walk_car_a", 4'(car_a), 4'b0001);
        chk("rst_walk_car_b", 4'(car_b), 4'b0100);
        chk("rst_walk_walk", 4'(ped_walk), 4'b0000);
        chk("rst_walk_wait", 4'(ped_wait), 4'b0000);
        goto(40);
        chk("rst_walk_no_req", 4'(car_a), 4'b0001);

`ifdef NIGHT_MODE_EN
        do_reset(0);
        night = 1'b1;
        goto(19); chk("night_a_grn", 4'(car_a), 4'b0001);
        goto(20); chk("night_on_a", 4'(car_a), 4'b0010);
                  chk("night_on_b", 4'(car_b), 4'b0010);
        goto(27); chk("night_on_last", 4'(car_a), 4'b0010);
        goto(28); chk("night_off_a", 4'(car_a), 4'b0000);
                  chk("night_off_b", 4'(car_b), 4'b0000);
        goto(30); ped_btn = 1'b1;
        goto(31); ped_btn = 1'b0;
        goto(35); chk("night_off_last", 4'(car_a), 4'b0000);
                  chk("night_no_latch", 4'(ped_wait), 4'b0000);
        goto(36); chk("night_on_again", 4'(car_b), 4'b0010);
        goto(40); night = 1'b0;
                  chk("night_walk_off", 4'(ped_walk), 4'b0000);
        goto(41); chk("night_exit_a", 4'(car_a), 4'b0100);
        goto(42); chk("night_exit_b", 4'(car_b), 4'b0100);
        goto(43); chk("night_back_a", 4'(car_a), 4'b0001);
        goto(50);
`endif

        model_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
